// File: rtl/dump_seq_multi.sv
// Multi-channel dump-switch sequencer: steps through a loadable table of {duration, pattern}
// phases on each start, then returns every channel to the idle pattern and pulses state_over.
module dump_seq_multi #(
  parameter int unsigned    CH       = 2,
  parameter int unsigned    CNT_W    = 8,
  parameter int unsigned    PH_MAX   = 4,
  parameter int unsigned    PA_W     = $clog2(PH_MAX),
  parameter logic [CH-1:0]  IDLE_PAT = {CH{1'b1}}
) (
  input  logic              clk_sys,
  input  logic              rst,
  input  logic              state_start,
  input  logic              abort,
  input  logic [PA_W:0]     nph,
  input  logic              cfg_we,
  input  logic [PA_W-1:0]   cfg_addr,
  input  logic [CNT_W-1:0]  cfg_dur,
  input  logic [CH-1:0]     cfg_pat,
  output logic [CH-1:0]     dump_off,
  output logic              busy,
  output logic [PA_W-1:0]   phase,
  output logic              state_over,
  output logic              cfg_err
);

  localparam logic [PA_W:0]  NphMax = (PA_W + 1)'(PH_MAX);
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  typedef enum logic {StIdle, StRun} state_e;

  state_e             state_q, state_d;
  logic [PA_W-1:0]    phase_q, phase_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PA_W:0]      nph_q, nph_d;
  logic [CH-1:0]      dump_q, dump_d;
  logic               over_q, over_d;
  logic               err_q, err_d;
  logic               tbl_we;

  logic [CNT_W-1:0]   dur_q [PH_MAX];
  logic [CH-1:0]      pat_q [PH_MAX];

  logic [PA_W-1:0]    phase_inc;
  logic [PA_W:0]      phase_ext;

  assign phase_inc = phase_q + 1'b1;
  assign phase_ext = {1'b0, phase_q} + 1'b1;

  // A programmed duration of zero runs for one cycle so the counter never wraps.
  function automatic logic [CNT_W-1:0] eff_dur(input logic [CNT_W-1:0] d);
    return (d == '0) ? CntOne : d;
  endfunction

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    nph_d   = nph_q;
    dump_d  = dump_q;
    over_d  = 1'b0;
    err_d   = 1'b0;
    tbl_we  = 1'b0;
    unique case (state_q)
      StIdle: begin
        tbl_we = cfg_we;
        if (state_start && !abort) begin
          if (nph == '0) begin
            over_d = 1'b1;
          end else if (nph > NphMax) begin
            err_d = 1'b1;
          end else begin
            state_d = StRun;
            phase_d = '0;
            cnt_d   = eff_dur(dur_q[0]);
            dump_d  = pat_q[0];
            nph_d   = nph;
          end
        end
      end
      StRun: begin
        err_d = cfg_we | state_start;
        if (abort) begin
          state_d = StIdle;
          phase_d = '0;
          cnt_d   = '0;
          dump_d  = IDLE_PAT;
        end else if (cnt_q == CntOne) begin
          if (phase_ext < nph_q) begin
            phase_d = phase_inc;
            cnt_d   = eff_dur(dur_q[phase_inc]);
            dump_d  = pat_q[phase_inc];
          end else begin
            state_d = StIdle;
            phase_d = '0;
            cnt_d   = '0;
            dump_d  = IDLE_PAT;
            over_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      phase_q <= '0;
      cnt_q   <= '0;
      nph_q   <= '0;
      dump_q  <= IDLE_PAT;
      over_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      nph_q   <= nph_d;
      dump_q  <= dump_d;
      over_q  <= over_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(PH_MAX); i++) begin
        dur_q[i] <= CntOne;
        pat_q[i] <= IDLE_PAT;
      end
    end else if (tbl_we) begin
      dur_q[cfg_addr] <= cfg_dur;
      pat_q[cfg_addr] <= cfg_pat;
    end
  end

  assign dump_off   = dump_q;
  assign busy       = (state_q == StRun);
  assign phase      = phase_q;
  assign state_over = over_q;
  assign cfg_err    = err_q;

endmodule
